// File: rtl/alu_pass_sequencer.sv
// Pass sequencer for the 16-lane SIMD ALU: issues NUM_PASSES passes per op,
// tracks results through a PIPE_DEPTH delay line and pulses done per op.
// Optional overlap of issue with drain: define ALU_SEQ_OVERLAP_EN.
module alu_pass_sequencer #(
  parameter int NUM_PASSES = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic [TAG_WIDTH-1:0]          issue_tag,
  output logic                          issue_ready,
  output logic                          in_wr_en,
  output logic                          in_shift_en,
  output logic                          alu_valid,
  output logic [$clog2(NUM_PASSES)-1:0] pass_idx,
  output logic                          out_shift_en,
  output logic                          done,
  output logic [TAG_WIDTH-1:0]          done_tag,
  output logic                          busy
);

  localparam int CW = $clog2(NUM_PASSES);
  localparam logic [CW-1:0] LAST    = CW'(NUM_PASSES - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(NUM_PASSES - 2);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DRAIN
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   accept;
  logic                   last_out;

  logic [PIPE_DEPTH-1:0]  dly_valid;
  logic [PIPE_DEPTH-1:0]  dly_last;
  logic [TAG_WIDTH-1:0]   dly_tag [PIPE_DEPTH];

  always_comb begin
    issue_ready = (state == IDLE);
`ifdef ALU_SEQ_OVERLAP_EN
    if (state == DRAIN) issue_ready = 1'b1;
`endif
  end

  assign accept       = issue_valid & issue_ready;
  assign in_wr_en     = accept;
  assign pass_idx     = cnt;
  assign out_shift_en = dly_valid[PIPE_DEPTH-1];
  assign last_out     = dly_valid[PIPE_DEPTH-1] & dly_last[PIPE_DEPTH-1];
  assign busy         = (state != IDLE) | (|dly_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tag_q       <= '0;
      alu_valid   <= 1'b0;
      in_shift_en <= 1'b0;
      done        <= 1'b0;
      done_tag    <= '0;
    end else begin
      // done is driven only by the delayed last-pass flag, never by FSM state
      done <= last_out;
      if (last_out) done_tag <= dly_tag[PIPE_DEPTH-1];

      unique case (state)
        IDLE, DRAIN: begin
          if (accept) begin
            state       <= EXEC;
            cnt         <= '0;
            tag_q       <= issue_tag;
            alu_valid   <= 1'b1;
            in_shift_en <= 1'b1;
          end else if (state == DRAIN && last_out) begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (cnt == LAST) begin
            state       <= DRAIN;
            cnt         <= '0;
            alu_valid   <= 1'b0;
            in_shift_en <= 1'b0;
          end else begin
            cnt         <= cnt + 1'b1;
            in_shift_en <= (cnt != LAST_M1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_valid <= '0;
      dly_last  <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) dly_tag[i] <= '0;
    end else begin
      dly_valid[0] <= alu_valid;
      dly_last[0]  <= alu_valid & (cnt == LAST);
      dly_tag[0]   <= tag_q;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_last[i]  <= dly_last[i-1];
        dly_tag[i]   <= dly_tag[i-1];
      end
    end
  end

endmodule
